button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 155 +++++++++++++++
 tb/tb_button_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronises, debounces and pulse-stretches the set-alarm/up/down keys.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat on the up and down keys.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
   parameter int unsigned PULSE_CYCLES        = 4,
   parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
   parameter int unsigned REPEAT_RATE_CYCLES  = 5000000,
   parameter bit          KEY_ACTIVE_LOW      = 1'b1
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [2:0] key_raw,
   output logic       btn_set_alarm,
   output logic       btn_up,
   output logic       btn_down,
   output logic [2:0] btn_held
);

   localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] PULSE_LOAD = 32'(PULSE_CYCLES - 1);

   logic [2:0] key_norm;
   logic [2:0] stable;
   logic [2:0] press_evt;
   logic [2:0] event_req;
   logic [2:0] pulse;

   genvar gi;

   assign key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

   for (gi = 0; gi < 3; gi++) begin : g_key
      logic        sync1_reg;
      logic        sync2_reg;
      logic        stable_reg;
      logic        stable_prev_reg;
      logic [31:0] db_cnt_reg;

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            stable_reg      <= 1'b0;
            stable_prev_reg <= 1'b0;
            db_cnt_reg      <= '0;
         end else begin
            sync1_reg       <= key_norm[gi];
            sync2_reg       <= sync1_reg;
            stable_prev_reg <= stable_reg;
            if (sync2_reg == stable_reg) begin
               db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
               stable_reg <= sync2_reg;
               db_cnt_reg <= '0;
            end else begin
               db_cnt_reg <= db_cnt_reg + 32'd1;
            end
         end
      end

      assign stable[gi]    = stable_reg;
      assign press_evt[gi] = stable_reg & ~stable_prev_reg;
   end

`ifdef BTN_AUTOREPEAT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_REPEAT} rpt_state_t;

   localparam logic [31:0] DELAY_LOAD = 32'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [31:0] RATE_LOAD  = 32'(REPEAT_RATE_CYCLES - 1);

   logic both_held;

   // Holding up and down together parks both FSMs so neither scrolls.
   assign both_held = stable[1] & stable[2];

   for (gi = 1; gi < 3; gi++) begin : g_rpt
      rpt_state_t  state_reg;
      logic [31:0] rpt_cnt_reg;
      logic        evt;

      always_comb begin
         evt = 1'b0;
         if (state_reg == ST_IDLE)
            evt = press_evt[gi];
         else
            evt = stable[gi] & ~both_held & (rpt_cnt_reg == 32'd0);
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            state_reg   <= ST_IDLE;
            rpt_cnt_reg <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (press_evt[gi]) begin
                     state_reg   <= ST_PRESS;
                     rpt_cnt_reg <= DELAY_LOAD;
                  end
               end
               default: begin
                  if (!stable[gi]) begin
                     state_reg <= ST_IDLE;
                  end else if (both_held) begin
                     state_reg   <= ST_PRESS;
                     rpt_cnt_reg <= DELAY_LOAD;
                  end else if (rpt_cnt_reg == 32'd0) begin
                     state_reg   <= ST_REPEAT;
                     rpt_cnt_reg <= RATE_LOAD;
                  end else begin
                     rpt_cnt_reg <= rpt_cnt_reg - 32'd1;
                  end
               end
            endcase
         end
      end

      assign event_req[gi] = evt;
   end

   assign event_req[0] = press_evt[0];
`else
   assign event_req = press_evt;
`endif

   // Events arriving while a pulse is already high are dropped.
   for (gi = 0; gi < 3; gi++) begin : g_pulse
      logic [31:0] cnt_reg;
      logic        out_reg;

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            cnt_reg <= '0;
            out_reg <= 1'b0;
         end else if (!out_reg) begin
            if (event_req[gi]) begin
               out_reg <= 1'b1;
               cnt_reg <= PULSE_LOAD;
            end
         end else if (cnt_reg != 32'd0) begin
            cnt_reg <= cnt_reg - 32'd1;
         end else begin
            out_reg <= 1'b0;
         end
      end

      assign pulse[gi] = out_reg;
   end

   assign btn_set_alarm = pulse[0];
   assign btn_up        = pulse[1];
   assign btn_down      = pulse[2];
   assign btn_held      = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner; expectations follow BTN_AUTOREPEAT_EN.
module tb_button_conditioner;

   localparam int DB = 8;
   localparam int PW = 2;
   localparam int RD = 40;
   localparam int RR = 10;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk_clk = 1'b0;
   logic       reset_reset_n = 1'b1;
   logic [2:0] key_raw = 3'b111;
   logic       btn_set_alarm;
   logic       btn_up;
   logic       btn_down;
   logic [2:0] btn_held;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   sa_q[$];
   int   up_q[$];
   int   dn_q[$];
   logic sa_prev = 1'b0;
   logic up_prev = 1'b0;
   logic dn_prev = 1'b0;

   button_conditioner #(
      .DEBOUNCE_CYCLES    (DB),
      .PULSE_CYCLES       (PW),
      .REPEAT_DELAY_CYCLES(RD),
      .REPEAT_RATE_CYCLES (RR),
      .KEY_ACTIVE_LOW     (1'b1)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .key_raw      (key_raw),
      .btn_set_alarm(btn_set_alarm),
      .btn_up       (btn_up),
      .btn_down     (btn_down),
      .btn_held     (btn_held)
   );

   always #5 clk_clk = ~clk_clk;

   always @(posedge clk_clk) cyc <= cyc + 1;

   // Log the cycle number of every rising edge of each event output.
   always @(negedge clk_clk) begin
      if (btn_set_alarm && !sa_prev) sa_q.push_back(cyc);
      if (btn_up && !up_prev)        up_q.push_back(cyc);
      if (btn_down && !dn_prev)      dn_q.push_back(cyc);
      sa_prev <= btn_set_alarm;
      up_prev <= btn_up;
      dn_prev <= btn_down;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_rises(input string tag, input int got[$], input int exp[$]);
      check_val({tag, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check_val($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
   endtask

   task automatic drive_at(input int c);
      while (cyc < c) begin
         @(posedge clk_clk);
         #1;
      end
   endtask

   task automatic at_neg(input int c);
      do @(negedge clk_clk); while (cyc < c);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int e[$];

      // reset state
      #2 reset_reset_n = 1'b0;
      #1;
      check_val("rst_held", int'(btn_held), 0);
      check_val("rst_sa", int'(btn_set_alarm), 0);
      check_val("rst_up", int'(btn_up), 0);
      check_val("rst_dn", int'(btn_down), 0);
      drive_at(3);
      reset_reset_n = 1'b1;
      drive_at(6);
      $display("reset: checks=%0d", total);

      // clean press on set-alarm
      sa_q.delete();
      p = cyc + 2;
      drive_at(p);
      key_raw[0] = 1'b0;
      at_neg(p + 9);  check_val("clean_held_pre", int'(btn_held[0]), 0);
      at_neg(p + 10); check_val("clean_held", int'(btn_held[0]), 1);
                      check_val("clean_sa_pre", int'(btn_set_alarm), 0);
      at_neg(p + 11); check_val("clean_sa_1", int'(btn_set_alarm), 1);
      at_neg(p + 12); check_val("clean_sa_2", int'(btn_set_alarm), 1);
      at_neg(p + 13); check_val("clean_sa_end", int'(btn_set_alarm), 0);
      drive_at(p + 30);
      key_raw[0] = 1'b1;
      at_neg(p + 39); check_val("clean_rel_pre", int'(btn_held[0]), 1);
      at_neg(p + 40); check_val("clean_rel", int'(btn_held[0]), 0);
      at_neg(p + 50);
      e.delete(); e.push_back(p + 11);
      check_rises("clean_sa", sa_q, e);
      $display("clean press: checks=%0d", total);

      // bouncing up key, then settles pressed
      up_q.delete();
      p = cyc + 2;
      for (int i = 0; i < 10; i++) begin
         drive_at(p + 3 * i);
         key_raw[1] = (i % 2 == 1);
      end
      p = p + 30;
      drive_at(p);
      key_raw[1] = 1'b0;
      at_neg(p + 9);  check_val("bounce_held_pre", int'(btn_held[1]), 0);
                      check_val("bounce_no_pulse", up_q.size(), 0);
      at_neg(p + 10); check_val("bounce_held", int'(btn_held[1]), 1);
      drive_at(p + 20);
      key_raw[1] = 1'b1;
      at_neg(p + 45);
      e.delete(); e.push_back(p + 11);
      check_rises("bounce_up", up_q, e);
      $display("bounce: checks=%0d", total);

      // long hold on down
      dn_q.delete();
      p = cyc + 2;
      drive_at(p);
      key_raw[2] = 1'b0;
      drive_at(p + 100);
      key_raw[2] = 1'b1;
      at_neg(p + 109); check_val("rpt_held_pre", int'(btn_held[2]), 1);
      at_neg(p + 110); check_val("rpt_held_rel", int'(btn_held[2]), 0);
      at_neg(p + 130);
      e.delete(); e.push_back(p + 11);
      if (AR) for (int i = 0; i < 6; i++) e.push_back(p + 11 + RD + RR * i);
      check_rises("repeat_dn", dn_q, e);
      $display("auto-repeat: checks=%0d", total);

      // up and down held together
      up_q.delete();
      dn_q.delete();
      p = cyc + 2;
      drive_at(p);
      key_raw[1] = 1'b0;
      drive_at(p + 5);
      key_raw[2] = 1'b0;
      drive_at(p + 105);
      key_raw[2] = 1'b1;
      at_neg(p + 114); check_val("both_held", int'(btn_held), 6);
      at_neg(p + 115); check_val("both_dn_rel", int'(btn_held), 2);
      drive_at(p + 180);
      key_raw[1] = 1'b1;
      at_neg(p + 210);
      e.delete(); e.push_back(p + 11);
      if (AR) for (int i = 0; i < 4; i++) e.push_back(p + 115 + RD + RR * i);
      check_rises("both_up", up_q, e);
      e.delete(); e.push_back(p + 16);
      check_rises("both_dn", dn_q, e);
      $display("both held: checks=%0d", total);

      // reset in the middle of a repeat pulse with the key still held
      dn_q.delete();
      p = cyc + 2;
      drive_at(p);
      key_raw[2] = 1'b0;
      at_neg(p + 61);
      drive_at(p + 62);
      check_val("mid_pre_dn", int'(btn_down), AR ? 1 : 0);
      reset_reset_n = 1'b0;
      #1;
      check_val("mid_rst_dn", int'(btn_down), 0);
      check_val("mid_rst_held", int'(btn_held), 0);
      check_val("mid_rst_up", int'(btn_up), 0);
      drive_at(p + 65);
      reset_reset_n = 1'b1;
      at_neg(p + 74); check_val("mid_held_pre", int'(btn_held[2]), 0);
      at_neg(p + 75); check_val("mid_held", int'(btn_held[2]), 1);
      at_neg(p + 76); check_val("mid_dn_press", int'(btn_down), 1);
      drive_at(p + 80);
      key_raw[2] = 1'b1;
      at_neg(p + 110);
      e.delete(); e.push_back(p + 11);
      if (AR) begin
         e.push_back(p + 51);
         e.push_back(p + 61);
      end
      e.push_back(p + 76);
      check_rises("mid_rst_dn", dn_q, e);
      $display("reset mid-repeat: checks=%0d", total);

      // set-alarm held a long time
      sa_q.delete();
      p = cyc + 2;
      drive_at(p);
      key_raw[0] = 1'b0;
      at_neg(p + 10);  check_val("long_held_a", int'(btn_held[0]), 1);
      at_neg(p + 100); check_val("long_held_b", int'(btn_held[0]), 1);
      at_neg(p + 150); check_val("long_sa_quiet", int'(btn_set_alarm), 0);
      drive_at(p + 200);
      key_raw[0] = 1'b1;
      at_neg(p + 209); check_val("long_held_c", int'(btn_held[0]), 1);
      at_neg(p + 210); check_val("long_rel", int'(btn_held[0]), 0);
      at_neg(p + 230);
      e.delete(); e.push_back(p + 11);
      check_rises("long_sa", sa_q, e);
      $display("set-alarm long hold: checks=%0d", total);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
